// File: rtl/settle_monitor.sv
// ---------------------------------------------------------------------------
// settle_monitor
//
// Watches a signed fixed-point sample stream and reports when it has entered
// and stayed inside a tolerance band around a target for HOLD_CYCLES
// consecutive samples.  It also reports the index of the first sample of
// that run and, optionally, the peak value seen while tracking.
//
// Optional feature macro: SETTLE_MONITOR_PEAK_EN
//   defined   -> peak tracking register and comparator are built
//   undefined -> o_peak is tied to zero in every state
//
// The block is scale-agnostic: EXPONENT only documents the fixed-point
// format shared by i_v_in, i_target and i_tol.
// ---------------------------------------------------------------------------
module settle_monitor #(
    parameter int WIDTH       = 25,
    parameter int EXPONENT    = -16,
    parameter int HOLD_CYCLES = 16,
    parameter int MAX_CYCLES  = 4096,
    parameter int TIME_WIDTH  = 32
) (
    input  logic                         i_emu_clk,
    input  logic                         i_emu_rst_n,
    input  logic                         i_start,
    input  logic signed [WIDTH-1:0]      i_v_in,
    input  logic signed [WIDTH-1:0]      i_target,
    input  logic        [WIDTH-1:0]      i_tol,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_settled,
    output logic                         o_timed_out,
    output logic        [TIME_WIDTH-1:0] o_settle_time,
    output logic signed [WIDTH-1:0]      o_peak
);

    // Run counter only has to reach HOLD_CYCLES (at most 65535).
    localparam int                    RUN_W     = 16;
    localparam logic [RUN_W-1:0]      LP_HOLD   = RUN_W'(HOLD_CYCLES);
    localparam logic [RUN_W-1:0]      LP_RUN_1  = {{(RUN_W-1){1'b0}}, 1'b1};
    localparam logic [TIME_WIDTH-1:0] LP_LAST_T = TIME_WIDTH'(MAX_CYCLES - 1);
    localparam logic [TIME_WIDTH-1:0] LP_T_MAX  = {TIME_WIDTH{1'b1}};
    localparam logic [TIME_WIDTH-1:0] LP_T_1    = {{(TIME_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIME_WIDTH-1:0] LP_T_0    = {TIME_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRACK   = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Band test: |v - tgt| <= tol, evaluated at WIDTH+1 bits so that the
    // difference of two full-range signed values can never wrap.
    // -----------------------------------------------------------------------
    function automatic logic f_in_band(
        input logic signed [WIDTH-1:0] v,
        input logic signed [WIDTH-1:0] tgt,
        input logic        [WIDTH-1:0] tol
    );
        logic [WIDTH:0] diff;
        logic [WIDTH:0] mag;
        diff = {v[WIDTH-1], v} - {tgt[WIDTH-1], tgt};
        if (diff[WIDTH]) begin
            mag = (~diff) + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            mag = diff;
        end
        return (mag <= {1'b0, tol});
    endfunction

    state_t                    r_state;
    state_t                    w_state_next;
    logic signed [WIDTH-1:0]   r_target;
    logic        [WIDTH-1:0]   r_tol;
    logic        [TIME_WIDTH-1:0] r_t;
    logic        [TIME_WIDTH-1:0] r_first;
    logic        [RUN_W-1:0]   r_run;
    logic        [TIME_WIDTH-1:0] r_settle_time;

    logic                      w_tracking;
    logic                      w_in_band;
    logic        [RUN_W-1:0]   w_run_inc;
    logic                      w_settle_hit;
    logic                      w_last_sample;
    logic        [TIME_WIDTH-1:0] w_t_inc;
    logic        [TIME_WIDTH-1:0] w_first_eff;
    logic                      w_unused_exponent;

    // EXPONENT carries format information only; it has no effect on logic.
    assign w_unused_exponent = (EXPONENT < 0);

    assign w_tracking    = (r_state == ST_TRACK);
    assign w_in_band     = f_in_band(i_v_in, r_target, r_tol);
    assign w_run_inc     = r_run + LP_RUN_1;
    assign w_settle_hit  = w_tracking && w_in_band && (w_run_inc == LP_HOLD);
    assign w_last_sample = (r_t == LP_LAST_T);
    // Sample index saturates instead of wrapping; timeout fires well before.
    assign w_t_inc       = (r_t == LP_T_MAX) ? r_t : (r_t + LP_T_1);
    // A run that starts on this very sample begins at the current index.
    assign w_first_eff   = (r_run == {RUN_W{1'b0}}) ? r_t : r_first;

    // State register with synchronous active-low reset.
    always_ff @(posedge i_emu_clk) begin
        if (!i_emu_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start re-arms from anywhere; settle beats timeout.
    always_comb begin
        w_state_next = r_state;
        if (i_start) begin
            w_state_next = ST_TRACK;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_next = ST_IDLE;
                ST_TRACK: begin
                    if (w_settle_hit) begin
                        w_state_next = ST_DONE;
                    end else if (w_last_sample) begin
                        w_state_next = ST_TIMEOUT;
                    end else begin
                        w_state_next = ST_TRACK;
                    end
                end
                ST_DONE:    w_state_next = ST_DONE;
                ST_TIMEOUT: w_state_next = ST_TIMEOUT;
                default:    w_state_next = ST_IDLE;
            endcase
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        o_busy      = 1'b0;
        o_settled   = 1'b0;
        o_timed_out = 1'b0;
        case (r_state)
            ST_IDLE:    o_busy      = 1'b0;
            ST_TRACK:   o_busy      = 1'b1;
            ST_DONE:    o_settled   = 1'b1;
            ST_TIMEOUT: o_timed_out = 1'b1;
            default:    o_busy      = 1'b0;
        endcase
        o_done = o_settled | o_timed_out;
    end

    // Measurement datapath: latch band on start, count samples and runs.
    always_ff @(posedge i_emu_clk) begin
        if (!i_emu_rst_n) begin
            r_target      <= {WIDTH{1'b0}};
            r_tol         <= {WIDTH{1'b0}};
            r_t           <= LP_T_0;
            r_first       <= LP_T_0;
            r_run         <= {RUN_W{1'b0}};
            r_settle_time <= LP_T_0;
        end else if (i_start) begin
            r_target      <= i_target;
            r_tol         <= i_tol;
            r_t           <= LP_T_0;
            r_first       <= LP_T_0;
            r_run         <= {RUN_W{1'b0}};
            r_settle_time <= LP_T_0;
        end else if (w_tracking) begin
            r_t <= w_t_inc;
            if (w_in_band) begin
                r_run   <= w_run_inc;
                r_first <= w_first_eff;
            end else begin
                r_run   <= {RUN_W{1'b0}};
                r_first <= r_first;
            end
            if (w_settle_hit) begin
                r_settle_time <= w_first_eff;
            end else begin
                r_settle_time <= r_settle_time;
            end
        end else begin
            r_t           <= r_t;
            r_first       <= r_first;
            r_run         <= r_run;
            r_settle_time <= r_settle_time;
        end
    end

    assign o_settle_time = r_settle_time;

`ifdef SETTLE_MONITOR_PEAK_EN
    localparam logic signed [WIDTH-1:0] LP_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [WIDTH-1:0] r_peak;

    // Running signed maximum of the samples consumed while tracking.
    always_ff @(posedge i_emu_clk) begin
        if (!i_emu_rst_n) begin
            r_peak <= {WIDTH{1'b0}};
        end else if (i_start) begin
            r_peak <= LP_MOST_NEG;
        end else if (w_tracking && (i_v_in > r_peak)) begin
            r_peak <= i_v_in;
        end else begin
            r_peak <= r_peak;
        end
    end

    assign o_peak = r_peak;
`else
    assign o_peak = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_settle_monitor.sv
// ---------------------------------------------------------------------------
// tb_settle_monitor
//
// Directed stimulus for settle_monitor (HOLD_CYCLES=16, MAX_CYCLES=100).
// A reference model keeps the list of samples consumed since the last
// start and derives every output from it by scanning for the first window
// of HOLD consecutive in-band samples; all outputs are compared against it
// after every clock edge, and literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_settle_monitor;

    localparam int WIDTH = 25;
    localparam int HOLD  = 16;
    localparam int MAXC  = 100;
    localparam int TW    = 32;
    localparam longint MOST_NEG = -(64'sd1 <<< (WIDTH - 1));

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic signed [WIDTH-1:0] v_in;
    logic signed [WIDTH-1:0] target;
    logic        [WIDTH-1:0] tol;
    logic                    busy;
    logic                    done;
    logic                    settled;
    logic                    timed_out;
    logic        [TW-1:0]    settle_time;
    logic signed [WIDTH-1:0] peak;

    int checks   = 0;
    int failures = 0;

    settle_monitor #(
        .WIDTH       (WIDTH),
        .EXPONENT    (-16),
        .HOLD_CYCLES (HOLD),
        .MAX_CYCLES  (MAXC),
        .TIME_WIDTH  (TW)
    ) dut (
        .i_emu_clk     (clk),
        .i_emu_rst_n   (rst_n),
        .i_start       (start),
        .i_v_in        (v_in),
        .i_target      (target),
        .i_tol         (tol),
        .o_busy        (busy),
        .o_done        (done),
        .o_settled     (settled),
        .o_timed_out   (timed_out),
        .o_settle_time (settle_time),
        .o_peak        (peak)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    longint hist [0:MAXC-1];
    int     m_n      = 0;
    bit     m_active = 1'b0;
    longint m_tgt    = 0;
    longint m_tol    = 0;

    function automatic bit m_in_band(longint v);
        longint d;
        d = v - m_tgt;
        if (d < 0) d = -d;
        return (d <= m_tol);
    endfunction

    // Index of the sample that first completes HOLD in-band samples, or -1.
    function automatic int m_settle_idx();
        for (int k = HOLD - 1; k < m_n; k++) begin
            bit ok;
            ok = 1'b1;
            for (int j = k - HOLD + 1; j <= k; j++) begin
                if (!m_in_band(hist[j])) ok = 1'b0;
            end
            if (ok) return k;
        end
        return -1;
    endfunction

    function automatic bit m_decided();
        return (m_settle_idx() >= 0) || (m_n >= MAXC);
    endfunction

    function automatic longint exp_peak(longint v);
`ifdef SETTLE_MONITOR_PEAK_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Apply what the DUT is about to sample at the coming edge.
    task automatic model_step();
        if (!rst_n) begin
            m_active = 1'b0;
            m_n      = 0;
        end else if (start) begin
            m_active = 1'b1;
            m_tgt    = longint'(target);
            m_tol    = longint'({1'b0, tol});
            m_n      = 0;
        end else if (m_active && !m_decided()) begin
            hist[m_n] = longint'(v_in);
            m_n++;
        end
    endtask

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int     k;
        bit     e_set, e_to, e_busy;
        longint e_st, e_pk;
        k      = m_settle_idx();
        e_set  = m_active && (k >= 0);
        e_to   = m_active && !e_set && (m_n >= MAXC);
        e_busy = m_active && !e_set && !e_to;
        e_st   = e_set ? longint'(k - HOLD + 1) : 0;
        if (!m_active) begin
            e_pk = 0;
        end else begin
            e_pk = MOST_NEG;
            for (int i = 0; i < m_n; i++) if (hist[i] > e_pk) e_pk = hist[i];
        end
        chk("busy",        {63'd0, busy},        {63'd0, e_busy});
        chk("done",        {63'd0, done},        {63'd0, (e_set | e_to)});
        chk("settled",     {63'd0, settled},     {63'd0, e_set});
        chk("timed_out",   {63'd0, timed_out},   {63'd0, e_to});
        chk("settle_time", {32'd0, settle_time}, e_st);
        chk("peak",        $signed(peak),        exp_peak(e_pk));
    endtask

    // One clock: model sees the current inputs, DUT clocks, then compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic arm(input longint tg, input longint tl);
        logic [63:0] tl_bits;
        logic [63:0] tg_bits;
        tg_bits = tg;
        tl_bits = tl;
        start  = 1'b1;
        target = tg_bits[WIDTH-1:0];
        tol    = tl_bits[WIDTH-1:0];
        tick();
        start  = 1'b0;
    endtask

    task automatic samples(input longint v, input int count);
        logic [63:0] vb;
        vb    = v;
        start = 1'b0;
        for (int i = 0; i < count; i++) begin
            v_in = vb[WIDTH-1:0];
            tick();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        v_in   = '0;
        target = '0;
        tol    = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset mid-TRACK aborts without reporting.
        arm(65536, 3277);
        chk("arm_peak_init", $signed(peak), exp_peak(MOST_NEG));
        samples(0, 5);
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy",  {63'd0, busy},        64'sd0);
        chk("rst_done",  {63'd0, done},        64'sd0);
        chk("rst_stime", {32'd0, settle_time}, 64'sd0);
        chk("rst_peak",  $signed(peak),        64'sd0);
        rst_n = 1'b1;
        tick();

        // Clean step: 10 zeros then on target.
        arm(65536, 3277);
        samples(0, 10);
        samples(65536, 15);
        chk("step_not_yet", {63'd0, settled}, 64'sd0);
        samples(65536, 1);
        chk("step_settled", {63'd0, settled},     64'sd1);
        chk("step_stime",   {32'd0, settle_time}, 64'sd10);
        chk("step_peak",    $signed(peak),        exp_peak(65536));
        samples(200000, 3);

        // Ringing: one overshoot breaks the first run.
        arm(65536, 3277);
        samples(65536, 5);
        samples(75000, 1);
        samples(65536, 16);
        chk("ring_settled", {63'd0, settled},     64'sd1);
        chk("ring_stime",   {32'd0, settle_time}, 64'sd6);
        chk("ring_peak",    $signed(peak),        exp_peak(75000));

        // Timeout: never in band.
        arm(65536, 3277);
        samples(0, 100);
        chk("to_timed_out", {63'd0, timed_out},   64'sd1);
        chk("to_settled",   {63'd0, settled},     64'sd0);
        chk("to_stime",     {32'd0, settle_time}, 64'sd0);
        samples(65536, 20);

        // Run completed exactly by the last allowed sample: settle wins.
        arm(65536, 3277);
        samples(0, 84);
        samples(65536, 16);
        chk("last_settled", {63'd0, settled},     64'sd1);
        chk("last_timeout", {63'd0, timed_out},   64'sd0);
        chk("last_stime",   {32'd0, settle_time}, 64'sd84);

        // Band edges: |d|==tol in band, |d|==tol+1 resets the run.
        arm(1000, 10);
        samples(1010, 5);
        samples(990, 5);
        samples(1011, 1);
        for (int i = 0; i < 8; i++) begin
            samples(1010, 1);
            samples(990, 1);
        end
        chk("edge_settled", {63'd0, settled},     64'sd1);
        chk("edge_stime",   {32'd0, settle_time}, 64'sd11);

        // Extreme difference must not wrap into the band.
        arm((64'sd1 <<< 24) - 1, 100);
        samples(-(64'sd1 <<< 24), 20);
        chk("ovf_busy",    {63'd0, busy},    64'sd1);
        chk("ovf_settled", {63'd0, settled}, 64'sd0);

        // Same extreme difference with the widest tolerance is in band.
        arm((64'sd1 <<< 24) - 1, (64'sd1 <<< 25) - 1);
        samples(-(64'sd1 <<< 24), 16);
        chk("wide_settled", {63'd0, settled},     64'sd1);
        chk("wide_stime",   {32'd0, settle_time}, 64'sd0);

        // Re-arm at index 8 of TRACK, then again from DONE.
        arm(0, 5);
        samples(0, 8);
        arm(0, 5);
        samples(100, 3);
        samples(2, 16);
        chk("rearm1_stime", {32'd0, settle_time}, 64'sd3);
        samples(100, 2);
        arm(0, 5);
        chk("rearm2_clear", {63'd0, done}, 64'sd0);
        samples(100, 5);
        samples(-5, 16);
        chk("rearm2_stime", {32'd0, settle_time}, 64'sd5);
        chk("rearm2_peak",  $signed(peak),        exp_peak(100));
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/settle_monitor.md
# settle_monitor

Downstream measurement stage for the real-valued filter under test. Consumes the fixed-point `v_out` sample stream on the emulator clock and, once armed, reports when the signal has entered and stayed inside a tolerance band around a target. It also reports the settling time in cycles and the peak value observed, which gives the testbench an on-chip pass/fail result without streaming every sample out of the emulator.

## Interface
Parameters:
- `WIDTH`, 25, bit width of the signed fixed-point sample, target and tolerance.
- `EXPONENT`, -16, fixed-point exponent shared by `v_in`, `target`, `tol`; the block itself is scale-agnostic.
- `HOLD_CYCLES`, 16, consecutive in-band samples required to declare settled; range 1..65535.
- `MAX_CYCLES`, 4096, samples allowed after arming before timeout; must be ≥ `HOLD_CYCLES`.
- `TIME_WIDTH`, 32, width of the cycle counter and `settle_time`.

Ports:
- `emu_clk` in 1: emulator clock; all state updates on its rising edge.
- `emu_rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle arm/re-arm pulse.
- `v_in` in `WIDTH`: signed sample, typically filter `v_out`.
- `target` in `WIDTH`: signed target value, latched on `start`.
- `tol` in `WIDTH`: unsigned band half-width, latched on `start`.
- `busy` out 1: high while tracking.
- `done` out 1: level; high once settled or timed out, until the next `start`.
- `settled` out 1: level; high in DONE.
- `timed_out` out 1: level; high in TIMEOUT.
- `settle_time` out `TIME_WIDTH`: sample index of the first sample of the qualifying in-band run.
- `peak` out `WIDTH`: signed maximum of `v_in` over the tracking window.

## Operation
- States: IDLE, TRACK, DONE, TIMEOUT.
- Reset (`emu_rst_n`=0 at an edge):
  - State goes to IDLE.
  - All outputs 0; `settle_time` 0; `peak` 0.
  - Internal counters 0.
  - Reset mid-TRACK aborts without reporting.
- `start`=1 in any state:
  - Latch `target` and `tol`.
  - Sample index t:=0, run:=0.
  - `peak` := most negative value.
  - Clear `settle_time`, `settled`, `timed_out`.
  - Enter TRACK. A `start` in TRACK restarts the measurement.
- TRACK, sample at index t (one sample per cycle, `start`=0):
  - Band test: d = `v_in` − target computed at `WIDTH`+1 bits, with no overflow. The sample is in band iff |d| ≤ tol; equality counts as in band.
  - In band: if run==0 then first:=t; run:=run+1.
  - Out of band: run:=0.
  - `peak` := max(`peak`, `v_in`) as a signed compare.
  - If this sample makes run==`HOLD_CYCLES`: `settle_time`:=first (or t when `HOLD_CYCLES`=1); go to DONE.
  - Else if t==`MAX_CYCLES`−1: go to TIMEOUT; `settle_time` stays 0.
  - If both conditions hold on the same sample, settle wins.
  - t increments each sample.
- DONE and TIMEOUT hold all outputs until `start` or reset; `v_in` is ignored.
- `busy`=1 only in TRACK. `done` = `settled` | `timed_out`. `settled` and `timed_out` are never both 1.

## Timing
- Inputs are registered-free. The sample on the `start` cycle is not evaluated; index 0 is the cycle after `start`.
- Status latency: the flags and `settle_time` update at the edge that consumes the deciding sample. They are visible the cycle after that sample is presented.
- `peak` updates one cycle after each TRACK sample.
- Counter width: t saturates at its maximum and never wraps. Timeout always fires first because `MAX_CYCLES` < 2^`TIME_WIDTH`.
- Throughput: one sample per `emu_clk`; no stall input.

## Configuration
- `SETTLE_MONITOR_PEAK_EN`:
  - Defined: peak tracking is compiled in as described.
  - Undefined: the comparator and register are removed; `peak` is a constant 0 in all states. All other behaviour is unchanged.

## Test plan
- Reset: assert `emu_rst_n`=0 for 3 cycles mid-TRACK → `busy`/`done`/`settled`/`timed_out`=0, `settle_time`=0, `peak`=0, state IDLE.
- Clean step: `EXPONENT`=−16, `target`=65536, `tol`=3277, `HOLD_CYCLES`=16; `v_in`=0 for 10 samples then 65536 → `settled`=1 one cycle after index 25, `settle_time`=10, `peak`=65536.
- Ringing: 5 in-band samples, 1 sample at 75000, then 16 in-band samples starting at index 6 → `settle_time`=6, `peak`=75000 (0 if `SETTLE_MONITOR_PEAK_EN` undefined).
- Timeout: `MAX_CYCLES`=100, `v_in` never in band → `timed_out`=1 after index 99, `settled`=0, `settle_time`=0. Separately, in band exactly when index 99 completes the run → `settled`=1, `timed_out`=0.
- Band edges: |d|==`tol` counts in band; |d|==`tol`+1 resets run. `target`=2^24−1 with `v_in`=−2^24 is out of band, with no overflow.
- Re-arm: `start` pulsed at index 8 of TRACK, and again in DONE → counters restart; a new `settle_time` is measured from the new index 0.
